// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / branch / memory-wait stall and flush controller
// Optional performance counters (StallCnt, FlushCnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rd_E,
  input  logic             MemRead_E,
  input  logic             PCSrc_E,
  input  logic             MemReq_M,
  input  logic             MemReady_M,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_W,
  output logic             MemTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYC);

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q;
  logic              freeze;
  logic              load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_q | (state_q == ERROR);
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (MemReq_M && !MemReady_M) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (MemReady_M) begin
          state_d = RUN;
        end else if (wait_q == WAIT_MAX) begin
          state_d = ERROR;
        end else if (wait_q != '1) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  // A freeze holds E, so a branch or load-use seen there is re-evaluated once the freeze lifts.
  assign freeze = ((state_q == RUN) && MemReq_M && !MemReady_M) ||
                  ((state_q == MEM_WAIT) && !MemReady_M) ||
                  (state_q == ERROR);

  assign load_use = MemRead_E && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    Flush_W = 1'b0;
    if (rst) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
      Flush_W = 1'b1;
    end else if (freeze) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
      Flush_W = 1'b1;
    end else if (PCSrc_E) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
    end else if (load_use) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end
  end

  assign MemTimeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Stall_F) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (Flush_E) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rd_E;
  logic       MemRead_E, PCSrc_E, MemReq_M, MemReady_M;
  logic       Stall_F, Stall_D, Stall_E, Stall_M;
  logic       Flush_D, Flush_E, Flush_W, MemTimeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] StallCnt, FlushCnt;
`endif
  logic [6:0] outs;
  int         errors = 0;
  int         checks = 0;

  localparam logic [6:0] IDLE   = 7'b0000000;
  localparam logic [6:0] FREEZE = 7'b1111001;
  localparam logic [6:0] LU     = 7'b1100010;
  localparam logic [6:0] BRANCH = 7'b0000110;
  localparam logic [6:0] RESET  = 7'b0000111;

  always #5 clk = ~clk;

  assign outs = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W};

  hazard_stall_ctrl #(.TIMEOUT_CYC(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1_D      (Rs1_D),
    .Rs2_D      (Rs2_D),
    .Rd_E       (Rd_E),
    .MemRead_E  (MemRead_E),
    .PCSrc_E    (PCSrc_E),
    .MemReq_M   (MemReq_M),
    .MemReady_M (MemReady_M),
    .Stall_F    (Stall_F),
    .Stall_D    (Stall_D),
    .Stall_E    (Stall_E),
    .Stall_M    (Stall_M),
    .Flush_D    (Flush_D),
    .Flush_E    (Flush_E),
    .Flush_W    (Flush_W),
    .MemTimeout (MemTimeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt)
`endif
  );

  // Apply one cycle of inputs at the falling edge and let combinational outputs settle.
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic pc, input logic req, input logic rdy);
    @(negedge clk);
    Rs1_D = rs1; Rs2_D = rs2; Rd_E = rd;
    MemRead_E = mr; PCSrc_E = pc; MemReq_M = req; MemReady_M = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== RESET) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, RESET); end
    checks++; if (MemTimeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", MemTimeout); end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== IDLE) begin errors++; $display("FAIL post_reset_idle got=%b exp=%b", outs, IDLE); end
  endtask

  task automatic test_load_use();
    drive(5, 0, 5, 1, 0, 0, 0);
    checks++; if (outs !== LU) begin errors++; $display("FAIL lu_rs1 got=%b exp=%b", outs, LU); end
    drive(0, 9, 0, 1, 0, 0, 0);
    checks++; if (outs !== IDLE) begin errors++; $display("FAIL lu_x0 got=%b exp=%b", outs, IDLE); end
    drive(3, 7, 7, 1, 0, 0, 0);
    checks++; if (outs !== LU) begin errors++; $display("FAIL lu_rs2 got=%b exp=%b", outs, LU); end
    drive(3, 4, 7, 1, 0, 0, 0);
    checks++; if (outs !== IDLE) begin errors++; $display("FAIL lu_nomatch got=%b exp=%b", outs, IDLE); end
    drive(7, 7, 7, 0, 0, 0, 0);
    checks++; if (outs !== IDLE) begin errors++; $display("FAIL lu_not_load got=%b exp=%b", outs, IDLE); end
  endtask

  task automatic test_branch();
    drive(0, 0, 0, 0, 1, 0, 0);
    checks++; if (outs !== BRANCH) begin errors++; $display("FAIL branch got=%b exp=%b", outs, BRANCH); end
    drive(1, 7, 7, 1, 1, 0, 0);
    checks++; if (outs !== BRANCH) begin errors++; $display("FAIL branch_over_lu got=%b exp=%b", outs, BRANCH); end
  endtask

  task automatic test_mem_wait();
    drive(0, 0, 0, 0, 0, 1, 0);
    checks++; if (outs !== FREEZE) begin errors++; $display("FAIL wait_c0 got=%b exp=%b", outs, FREEZE); end
    drive(5, 0, 5, 1, 0, 1, 0);
    checks++; if (outs !== FREEZE) begin errors++; $display("FAIL wait_c1_lu_ignored got=%b exp=%b", outs, FREEZE); end
    drive(0, 0, 0, 0, 0, 1, 0);
    checks++; if (outs !== FREEZE) begin errors++; $display("FAIL wait_c2 got=%b exp=%b", outs, FREEZE); end
    drive(0, 0, 0, 0, 0, 1, 1);
    checks++; if (outs !== IDLE) begin errors++; $display("FAIL wait_done got=%b exp=%b", outs, IDLE); end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== IDLE) begin errors++; $display("FAIL wait_back_run got=%b exp=%b", outs, IDLE); end
  endtask

  task automatic test_freeze_branch();
    drive(0, 0, 0, 0, 1, 1, 0);
    checks++; if (outs !== FREEZE) begin errors++; $display("FAIL frz_branch_held got=%b exp=%b", outs, FREEZE); end
    drive(0, 0, 0, 0, 1, 1, 1);
    checks++; if (outs !== BRANCH) begin errors++; $display("FAIL frz_branch_release got=%b exp=%b", outs, BRANCH); end
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(2, 0, 2, 1, 0, 0, 1);
    checks++; if (outs !== LU) begin errors++; $display("FAIL frz_lu_release got=%b exp=%b", outs, LU); end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== IDLE) begin errors++; $display("FAIL frz_after got=%b exp=%b", outs, IDLE); end
  endtask

  task automatic test_timeout_edge();
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 1);
    checks++; if (outs !== IDLE) begin errors++; $display("FAIL edge_ready_at_limit got=%b exp=%b", outs, IDLE); end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== IDLE) begin errors++; $display("FAIL edge_no_error got=%b exp=%b", outs, IDLE); end
    checks++; if (MemTimeout !== 1'b0) begin errors++; $display("FAIL edge_timeout got=%b exp=0", MemTimeout); end
  endtask

  task automatic test_timeout();
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) drive(0, 0, 0, 0, 0, 1, 0);
    checks++; if (MemTimeout !== 1'b0) begin errors++; $display("FAIL to_wait5_flag got=%b exp=0", MemTimeout); end
    drive(0, 0, 0, 0, 1, 0, 1);
    checks++; if (outs !== FREEZE) begin errors++; $display("FAIL to_error_freeze got=%b exp=%b", outs, FREEZE); end
    checks++; if (MemTimeout !== 1'b0) begin errors++; $display("FAIL to_error_first got=%b exp=0", MemTimeout); end
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (MemTimeout !== 1'b1) begin errors++; $display("FAIL to_flag_rise got=%b exp=1", MemTimeout); end
    checks++; if (outs !== FREEZE) begin errors++; $display("FAIL to_error_hold got=%b exp=%b", outs, FREEZE); end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== RESET) begin errors++; $display("FAIL to_rst_outs got=%b exp=%b", outs, RESET); end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 1);
    checks++; if (outs !== IDLE) begin errors++; $display("FAIL to_after_rst got=%b exp=%b", outs, IDLE); end
    checks++; if (MemTimeout !== 1'b0) begin errors++; $display("FAIL to_flag_clear got=%b exp=0", MemTimeout); end
  endtask

  task automatic test_rst_mid_wait();
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== RESET) begin errors++; $display("FAIL midrst_outs got=%b exp=%b", outs, RESET); end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (outs !== IDLE) begin errors++; $display("FAIL midrst_no_freeze got=%b exp=%b", outs, IDLE); end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (StallCnt !== 4'd0) begin errors++; $display("FAIL perf_rst_stall got=%0d exp=0", StallCnt); end
    for (int i = 0; i < 17; i++) drive(5, 0, 5, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (StallCnt !== 4'd1) begin errors++; $display("FAIL perf_stall_wrap got=%0d exp=1", StallCnt); end
    checks++; if (FlushCnt !== 4'd1) begin errors++; $display("FAIL perf_flush_wrap got=%0d exp=1", FlushCnt); end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (StallCnt !== 4'd0) begin errors++; $display("FAIL perf_clear_stall got=%0d exp=0", StallCnt); end
    checks++; if (FlushCnt !== 4'd0) begin errors++; $display("FAIL perf_clear_flush got=%0d exp=0", FlushCnt); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    Rs1_D = '0; Rs2_D = '0; Rd_E = '0;
    MemRead_E = 1'b0; PCSrc_E = 1'b0; MemReq_M = 1'b0; MemReady_M = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_freeze_branch();
    test_timeout_edge();
    test_timeout();
    test_rst_mid_wait();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 255: max consecutive MemWait cycles before timeout error.
REQ-002 SHALL provide parameter CNT_W, default 32: width of performance counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 Rs1_D, Rs2_D  in  5 each  source registers of the instruction in Decode.
REQ-006 Rd_E  in  5  destination register of the instruction in Execute.
REQ-007 MemRead_E  in  1  Execute instruction is a load.
REQ-008 PCSrc_E  in  1  taken branch or jump resolved in Execute.
REQ-009 MemReq_M, MemReady_M  in  1 each  data-memory request and completion handshake for Memory stage.
REQ-010 Stall_F, Stall_D, Stall_E, Stall_M  out  1 each  hold the PC and the D/E/M pipeline registers.
REQ-011 Flush_D, Flush_E, Flush_W  out  1 each  bubble into the D/E/W pipeline registers.
REQ-012 MemTimeout  out  1  sticky error flag.
REQ-013 StallCnt, FlushCnt  out  CNT_W each  performance counters; present only under the REQ-033 macro.

Function
REQ-014 SHALL implement a 3-state FSM: RUN, MEM_WAIT, ERROR.
REQ-015 RUN->MEM_WAIT when MemReq_M=1 and MemReady_M=0; MEM_WAIT->RUN on the first cycle with MemReady_M=1.
REQ-016 In MEM_WAIT, a wait counter SHALL increment each cycle, saturating; it SHALL clear when MEM_WAIT is entered.
REQ-017 MEM_WAIT->ERROR when the wait counter equals TIMEOUT_CYC and MemReady_M=0; ERROR SHALL persist until rst.
REQ-018 Memory freeze: Stall_F=Stall_D=Stall_E=Stall_M=1 and Flush_W=1, combinationally, in any cycle where (state RUN, MemReq_M=1, MemReady_M=0), state=MEM_WAIT with MemReady_M=0, or state=ERROR.
REQ-019 During a memory freeze, Flush_D=Flush_E=0; PCSrc_E and load-use SHALL be ignored, because the E-stage contents are held.
REQ-020 The cycle in which MemReady_M=1 completes a wait SHALL NOT freeze; load-use and branch rules apply normally in that cycle.
REQ-021 Load-use hazard (LU) = MemRead_E & (Rd_E!=0) & ((Rd_E==Rs1_D) | (Rd_E==Rs2_D)).
REQ-022 If LU and not PCSrc_E and no freeze: Stall_F=Stall_D=1 and Flush_E=1 for exactly that cycle; Stall_E=Stall_M=0.
REQ-023 If PCSrc_E and no freeze: Flush_D=Flush_E=1 and all stalls=0; a taken branch SHALL override a simultaneous LU.
REQ-024 With no freeze, no LU and no PCSrc_E, all stall/flush outputs SHALL be 0.
REQ-025 Rs1_D or Rs2_D equal to x0 SHALL never produce LU, because Rd_E=0 is excluded.
REQ-026 MemTimeout SHALL rise in the cycle after ERROR is entered and remain 1 until rst.
REQ-027 Latency: all stall/flush outputs are combinational (0-cycle) from inputs and current state.

Reset
REQ-028 While rst=1: all stalls=0, Flush_D=Flush_E=Flush_W=1, so the pipeline is cleared.
REQ-029 After rst the state SHALL be RUN, with wait counter=0 and MemTimeout=0.
REQ-030 If StallCnt and FlushCnt are present, they SHALL be 0 after rst.
REQ-031 An rst asserted mid-MEM_WAIT or in ERROR SHALL return to RUN on the next edge, with no residual freeze.

Configuration
REQ-032 Exactly one optional feature: performance counters.
REQ-033 With HAZARD_PERF_CNT_EN defined, StallCnt SHALL increment on every cycle with Stall_F=1 outside rst, and FlushCnt on every cycle with Flush_E=1 outside rst; both SHALL wrap modulo 2^CNT_W.
REQ-034 Without HAZARD_PERF_CNT_EN, the StallCnt and FlushCnt ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 MemRead_E=1, Rd_E=5, Rs1_D=5, PCSrc_E=0 -> Stall_F=Stall_D=Flush_E=1 for one cycle, Stall_E=0; with Rd_E=0, Rs1_D=0 -> all outputs 0.
REQ-036 LU (Rd_E=7, Rs2_D=7) together with PCSrc_E=1 -> Flush_D=Flush_E=1, Stall_F=0.
REQ-037 MemReq_M=1 with MemReady_M low for 3 cycles, then high -> freeze outputs 1 for 3 cycles, 0 on the 4th; state returns to RUN.
REQ-038 TIMEOUT_CYC=4 with MemReady_M held low -> ERROR after the 5th wait cycle, MemTimeout=1 and freeze held; rst 1 cycle -> RUN, MemTimeout=0.
REQ-039 PCSrc_E=1 during a freeze -> Flush_D=Flush_E=0; after MemReady_M=1 in the same cycle -> Flush_D=Flush_E=1.
REQ-040 With HAZARD_PERF_CNT_EN, CNT_W=4 and 17 stall cycles -> StallCnt=1 (wrap); rst -> 0.
